// File: rtl/pwm_periph_pkg.sv
// Shared constants and types for the PWM peripheral register interface.
package pwm_periph_pkg;

  localparam int ADDRESS_WIDTH = 6;
  localparam int ADDRESS_MAX   = 48;

  // Command byte layout: bit 7 selects write, bit 6 is reserved, bits 5:0 hold the start address.
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_ADDR_MSB  = 5;
  localparam int CMD_ADDR_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } bridge_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, plus a third flop for edge detection.
module spi_sync_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic level,
  output logic rise,
  output logic fall
);

  // Index 0 and 1 form the synchroniser; index 2 holds the previous synchronised level.
  logic [2:0] sync_q;

  // Shift the pin through the chain; reset to zero so a pin already low never looks like a fall.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], i_pin};
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_register_bridge.sv
// SPI mode-0 slave that converts host frames into register-file writes and serial read-back.
module spi_register_bridge #(
  parameter int ADDRESS_WIDTH = pwm_periph_pkg::ADDRESS_WIDTH,
  parameter int ADDRESS_MAX   = pwm_periph_pkg::ADDRESS_MAX
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_sclk,
  input  logic                     i_cs_n,
  input  logic                     i_mosi,
  output logic                     o_miso,
  output logic                     o_write_en,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic [7:0]               o_data,
  input  logic [7:0]               i_rd_data
);

  import pwm_periph_pkg::*;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = ADDRESS_MAX[ADDRESS_WIDTH-1:0];
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [1:0] mosi_sync;
  logic mosi_level;

  bridge_state_t state, state_next;
  logic [2:0] bit_count;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic [7:0] tx_shift;
  logic inc_pending;
  logic byte_done;
  logic [ADDRESS_WIDTH-1:0] next_address;

  spi_sync_edge u_sclk_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_pin   (i_sclk),
    .level   (sclk_level),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  spi_sync_edge u_cs_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_pin   (i_cs_n),
    .level   (cs_level),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  // MOSI gets the same two-flop delay as SCLK so it lines up with the detected rising edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mosi_sync <= 2'b00;
    end else begin
      mosi_sync <= {mosi_sync[0], i_mosi};
    end
  end

  assign mosi_level = mosi_sync[1];
  assign rx_byte    = {rx_shift, mosi_level};
  assign byte_done  = sclk_rise && (bit_count == 3'd7);

  // Increment modulo ADDRESS_MAX+1; (a+1)-(MAX+1) == a-MAX also folds out-of-range addresses.
  assign next_address = (o_address >= ADDR_MAX) ? (o_address - ADDR_MAX) : (o_address + ADDR_ONE);

  assign o_miso = tx_shift[7] & ~cs_level;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frames start only on a CS_N fall with SCLK idle low, and every frame ends on the CS_N rise.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cs_fall && !sclk_level) begin
          state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
        end else if (byte_done) begin
          state_next = rx_byte[CMD_WRITE_BIT] ? ST_WRITE : ST_READ;
        end
      end
      default: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // Bit/byte datapath: receive shift, write strobe, address stepping and the MISO shift register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_write_en  <= 1'b0;
      o_address   <= '0;
      o_data      <= 8'h00;
      bit_count   <= 3'd0;
      rx_shift    <= 7'd0;
      tx_shift    <= 8'h00;
      inc_pending <= 1'b0;
    end else begin
      o_write_en <= 1'b0;
      if (inc_pending) begin
        o_address   <= next_address;
        inc_pending <= 1'b0;
      end
      if (state == ST_IDLE || cs_rise) begin
        bit_count <= 3'd0;
        rx_shift  <= 7'd0;
        tx_shift  <= 8'h00;
      end else begin
        if (sclk_rise) begin
          bit_count <= bit_count + 3'd1;
          rx_shift  <= rx_byte[6:0];
          if (bit_count == 3'd7) begin
            case (state)
              ST_CMD:   o_address <= rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
              ST_WRITE: begin
                o_data      <= rx_byte;
                o_write_en  <= (o_address <= ADDR_MAX);
                inc_pending <= 1'b1;
              end
              ST_READ:  o_address <= next_address;
              default:  ;
            endcase
          end
        end
        if (sclk_fall && state == ST_READ) begin
          if (bit_count == 3'd0) begin
            tx_shift <= (o_address > ADDR_MAX) ? 8'h00 : i_rd_data;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_register_bridge.sv
// Self-checking bench for spi_register_bridge: directed frames followed by random frames.
module tb_spi_register_bridge;

  localparam int HALF = 50;
  localparam int AMAX = 48;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_sclk;
  logic       i_cs_n;
  logic       i_mosi;
  logic       o_miso;
  logic       o_write_en;
  logic [5:0] o_address;
  logic [7:0] o_data;
  logic [7:0] i_rd_data;

  logic [7:0]  rd_table [64];
  logic [7:0]  host_tx [$];
  logic [7:0]  host_rx [$];
  logic [7:0]  partial_byte;
  logic [13:0] wr_q [$];
  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  spi_register_bridge dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_sclk     (i_sclk),
    .i_cs_n     (i_cs_n),
    .i_mosi     (i_mosi),
    .o_miso     (o_miso),
    .o_write_en (o_write_en),
    .o_address  (o_address),
    .o_data     (o_data),
    .i_rd_data  (i_rd_data)
  );

  // Register file stand-in: combinational read of a bench-owned table.
  always_comb i_rd_data = rd_table[o_address];

  // Record every cycle the write strobe is high, away from the active edge.
  always @(negedge i_clk) begin
    if (o_write_en === 1'b1) wr_q.push_back({o_address, o_data});
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int nextAddr(input int a);
    return (a + 1) % (AMAX + 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sendBits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      i_mosi = b[i];
      #HALF;
      r[i] = o_miso;
      i_sclk = 1'b1;
      #HALF;
      i_sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input int partial_bits);
    logic [7:0] r;
    host_rx.delete();
    wr_q.delete();
    i_cs_n = 1'b0;
    #HALF;
    sendBits(cmd, 8, r);
    foreach (host_tx[i]) begin
      sendBits(host_tx[i], 8, r);
      host_rx.push_back(r);
    end
    if (partial_bits > 0) sendBits(partial_byte, partial_bits, r);
    #HALF;
    i_cs_n = 1'b1;
    #(4 * HALF);
  endtask

  // Expected behaviour from the frame contents: addresses step modulo 49, out-of-range is inert.
  task automatic verifyFrame(input string tag, input logic [7:0] cmd);
    int a;
    logic [13:0] exp_wr [$];
    a = int'(cmd[5:0]);
    if (cmd[7]) begin
      foreach (host_tx[i]) begin
        if (a <= AMAX) exp_wr.push_back({6'(a), host_tx[i]});
        a = nextAddr(a);
      end
      checkOutput({tag, "_wr_count"}, 16'(wr_q.size()), 16'(exp_wr.size()));
      foreach (exp_wr[i]) begin
        if (i < wr_q.size()) checkOutput($sformatf("%s_wr%0d", tag, i), 16'(wr_q[i]), 16'(exp_wr[i]));
      end
    end else begin
      foreach (host_tx[i]) begin
        checkOutput($sformatf("%s_rd%0d", tag, i), 16'(host_rx[i]),
                    16'((a <= AMAX) ? rd_table[6'(a)] : 8'h00));
        a = nextAddr(a);
      end
      checkOutput({tag, "_wr_count"}, 16'(wr_q.size()), 16'd0);
    end
    checkOutput({tag, "_addr"}, 16'(o_address), 16'(a));
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] cmd;
    int n;

    i_reset = 1'b1;
    i_sclk = 1'b0;
    i_cs_n = 1'b1;
    i_mosi = 1'b0;
    partial_byte = 8'h00;
    for (int a = 0; a < 64; a++) rd_table[a] = 8'(a + 64);

    #22;
    checkOutput("reset_write_en", 16'(o_write_en), 16'd0);
    checkOutput("reset_address", 16'(o_address), 16'd0);
    checkOutput("reset_data", 16'(o_data), 16'd0);
    checkOutput("reset_miso", 16'(o_miso), 16'd0);
    #10;
    i_reset = 1'b0;
    #70;

    host_tx = '{8'hA5};
    applyStimulus(8'h81, 0);
    verifyFrame("single_write", 8'h81);
    checkOutput("single_write_data", 16'(o_data), 16'h00A5);

    host_tx = '{8'h11, 8'h22, 8'h33};
    applyStimulus(8'hAF, 0);
    verifyFrame("burst_wrap", 8'hAF);

    host_tx = '{8'h00, 8'h00};
    applyStimulus(8'h05, 0);
    verifyFrame("burst_read", 8'h05);
    checkOutput("burst_read_first", 16'(host_rx[0]), 16'h0045);
    checkOutput("burst_read_second", 16'(host_rx[1]), 16'h0046);

    host_tx = '{8'h77};
    applyStimulus(8'hBF, 0);
    verifyFrame("oor_write", 8'hBF);

    host_tx = '{8'h00};
    applyStimulus(8'h3F, 0);
    verifyFrame("oor_read", 8'h3F);

    host_tx.delete();
    partial_byte = 8'hC3;
    applyStimulus(8'h8A, 5);
    verifyFrame("abort", 8'h8A);

    host_tx = '{8'h5A};
    applyStimulus(8'h80, 0);
    verifyFrame("after_abort", 8'h80);

    // Reset in the middle of a read byte, then confirm SCLK is ignored until a fresh CS_N fall.
    wr_q.delete();
    i_cs_n = 1'b0;
    #HALF;
    sendBits(8'h05, 8, r);
    sendBits(8'h00, 1, r);
    #30;
    checkOutput("midread_miso", 16'(o_miso), 16'd1);
    checkOutput("midread_address", 16'(o_address), 16'd5);
    i_reset = 1'b1;
    #1;
    checkOutput("midreset_write_en", 16'(o_write_en), 16'd0);
    checkOutput("midreset_address", 16'(o_address), 16'd0);
    checkOutput("midreset_data", 16'(o_data), 16'd0);
    checkOutput("midreset_miso", 16'(o_miso), 16'd0);
    #19;
    i_reset = 1'b0;
    sendBits(8'hFF, 8, r);
    sendBits(8'hFF, 8, r);
    #HALF;
    checkOutput("ignored_wr_count", 16'(wr_q.size()), 16'd0);
    checkOutput("ignored_address", 16'(o_address), 16'd0);
    i_cs_n = 1'b1;
    #(4 * HALF);

    host_tx = '{8'h01};
    applyStimulus(8'h83, 0);
    verifyFrame("post_reset", 8'h83);

    for (int f = 0; f < 20; f++) begin
      for (int a = 0; a < 64; a++) rd_table[a] = 8'($urandom);
      cmd = 8'($urandom);
      n = int'($urandom_range(0, 4));
      host_tx.delete();
      for (int k = 0; k < n; k++) host_tx.push_back(8'($urandom));
      applyStimulus(cmd, 0);
      verifyFrame($sformatf("rand%0d", f), cmd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
